// File: rtl/sync_merge_arbiter_if.sv
// ---------------------------------------------------------------------------
// Module  : sync_merge_arbiter_if
// Brief   : Handshake bundle for the two-input merge stage (a, b in; one out).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sync_merge_arbiter_if #(
   parameter int WIDTH = 40
);
   logic             Send_in_a;
   logic [WIDTH-1:0] PACKET_IN_INTERNAL;
   logic             Ack_out_a;
   logic             Send_in_b;
   logic [WIDTH-1:0] PACKET_IN_EXTERNAL;
   logic             Ack_out_b;
   logic             Send_out;
   logic [WIDTH-1:0] PACKET_OUT;
   logic             Ack_in;
   logic             SEL;

   modport slave (
      input  Send_in_a, PACKET_IN_INTERNAL,
      output Ack_out_a,
      input  Send_in_b, PACKET_IN_EXTERNAL,
      output Ack_out_b,
      output Send_out, PACKET_OUT, SEL,
      input  Ack_in
   );

   modport master (
      output Send_in_a, PACKET_IN_INTERNAL,
      input  Ack_out_a,
      output Send_in_b, PACKET_IN_EXTERNAL,
      input  Ack_out_b,
      input  Send_out, PACKET_OUT, SEL,
      output Ack_in
   );
endinterface

`default_nettype wire

// File: rtl/sync_merge_arbiter.sv
// ---------------------------------------------------------------------------
// Module  : sync_merge_arbiter
// Brief   : Internal-priority merge of two Send/Ack channels into a one-entry
//           output register, with a starvation bound for the external side.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_merge_arbiter #(
   parameter int WIDTH      = 40,
   parameter int STARVE_MAX = 3
) (
   input  wire logic             CLK,
   input  wire logic             MR,
   sync_merge_arbiter_if.slave   bus
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_packet;
   logic [WIDTH-1:0] w_packet_nxt;
   logic             r_sel;
   logic             w_sel_nxt;
   logic [CNT_W-1:0] r_starve;
   logic [CNT_W-1:0] w_starve_nxt;
   logic             w_can_accept;
   logic             w_grant_a;
   logic             w_grant_b;

   always_ff @(posedge CLK) begin
      if (MR) begin
         r_state  <= S_EMPTY;
         r_packet <= '0;
         r_sel    <= 1'b0;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_packet <= w_packet_nxt;
         r_sel    <= w_sel_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_packet_nxt = r_packet;
      w_sel_nxt    = r_sel;
      w_starve_nxt = r_starve;

      // Ack_in only frees the slot when something is actually held.
      w_can_accept = !MR && ((r_state == S_EMPTY) || bus.Ack_in);
      w_grant_b    = w_can_accept && bus.Send_in_b &&
                     (!bus.Send_in_a || (r_starve == C_STARVE_MAX));
      w_grant_a    = w_can_accept && bus.Send_in_a && !w_grant_b;

      if (w_grant_a) begin
         w_packet_nxt = bus.PACKET_IN_INTERNAL;
         w_sel_nxt    = 1'b0;
         w_state_nxt  = S_FULL;
      end else if (w_grant_b) begin
         w_packet_nxt = bus.PACKET_IN_EXTERNAL;
         w_sel_nxt    = 1'b1;
         w_state_nxt  = S_FULL;
      end else if ((r_state == S_FULL) && bus.Ack_in) begin
         w_state_nxt  = S_EMPTY;
      end

      // Counts internal wins only while external is waiting.
      if (w_grant_b || !bus.Send_in_b) begin
         w_starve_nxt = '0;
      end else if (w_grant_a) begin
         w_starve_nxt = r_starve + CNT_W'(1);
      end
   end

   assign bus.Ack_out_a  = w_grant_a;
   assign bus.Ack_out_b  = w_grant_b;
   assign bus.Send_out   = (r_state == S_FULL);
   assign bus.PACKET_OUT = r_packet;
   assign bus.SEL        = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_sync_merge_arbiter.sv
// ---------------------------------------------------------------------------
// Module  : tb_sync_merge_arbiter
// Brief   : Vector table, directed corner sequences and a randomized run
//           against a slot/wait-count reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sync_merge_arbiter;

   localparam int WIDTH      = 40;
   localparam int STARVE_MAX = 3;

   logic CLK = 1'b0;
   logic MR;

   sync_merge_arbiter_if #(.WIDTH(WIDTH)) bus ();

   sync_merge_arbiter #(
      .WIDTH      (WIDTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .CLK (CLK),
      .MR  (MR),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: an occupied slot plus how many times external has lost.
   bit             m_full = 1'b0;
   bit             m_sel  = 1'b0;
   logic [WIDTH-1:0] m_pkt = '0;
   int             m_wait = 0;
   int             m_g;

   function automatic int model_grant();
      if (MR || (m_full && !bus.Ack_in)) return 0;
      if (bus.Send_in_a && bus.Send_in_b) return (m_wait >= STARVE_MAX) ? 2 : 1;
      if (bus.Send_in_a) return 1;
      if (bus.Send_in_b) return 2;
      return 0;
   endfunction

   always_comb m_g = model_grant();

   always @(posedge CLK) begin
      if (MR) begin
         m_full <= 1'b0;
         m_pkt  <= '0;
         m_sel  <= 1'b0;
         m_wait <= 0;
      end else begin
         if (m_g == 1) begin
            m_pkt  <= bus.PACKET_IN_INTERNAL;
            m_sel  <= 1'b0;
            m_full <= 1'b1;
         end else if (m_g == 2) begin
            m_pkt  <= bus.PACKET_IN_EXTERNAL;
            m_sel  <= 1'b1;
            m_full <= 1'b1;
         end else if (bus.Ack_in) begin
            m_full <= 1'b0;
         end
         if (m_g == 2 || !bus.Send_in_b) m_wait <= 0;
         else if (m_g == 1)              m_wait <= m_wait + 1;
      end
   end

   typedef struct {
      logic             mr;
      logic             sa;
      logic [WIDTH-1:0] pa;
      logic             sb;
      logic [WIDTH-1:0] pb;
      logic             ack;
      logic             ea;
      logic             eb;
      logic             eso;
      logic             epc;
      logic [WIDTH-1:0] ep;
      logic             es;
   } vec_t;

   function automatic vec_t v(input logic mr, input logic sa, input logic [WIDTH-1:0] pa,
                              input logic sb, input logic [WIDTH-1:0] pb, input logic ack,
                              input logic ea, input logic eb, input logic eso,
                              input logic epc, input logic [WIDTH-1:0] ep, input logic es);
      vec_t r;
      r.mr = mr; r.sa = sa; r.pa = pa; r.sb = sb; r.pb = pb; r.ack = ack;
      r.ea = ea; r.eb = eb; r.eso = eso; r.epc = epc; r.ep = ep; r.es = es;
      return r;
   endfunction

   task automatic drive(input logic mr, input logic sa, input logic [WIDTH-1:0] pa,
                        input logic sb, input logic [WIDTH-1:0] pb, input logic ack);
      MR                     = mr;
      bus.Send_in_a          = sa;
      bus.PACKET_IN_INTERNAL = pa;
      bus.Send_in_b          = sb;
      bus.PACKET_IN_EXTERNAL = pb;
      bus.Ack_in             = ack;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   vec_t vt[$];
   logic got_a, got_b;
   logic prev_b;

   initial begin
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      next_cycle();

      // ---------------- vector table ----------------
      vt.push_back(v(1, 1, 40'h11, 1, 40'h22, 0,  0, 0, 0, 1, 40'h0,  0));
      vt.push_back(v(1, 1, 40'h11, 1, 40'h22, 1,  0, 0, 0, 1, 40'h0,  0));
      vt.push_back(v(0, 1, 40'hAA, 0, 40'h0,  0,  1, 0, 0, 1, 40'h0,  0));
      vt.push_back(v(0, 0, 40'h0,  0, 40'h0,  0,  0, 0, 1, 1, 40'hAA, 0));
      vt.push_back(v(0, 0, 40'h0,  0, 40'h0,  0,  0, 0, 1, 1, 40'hAA, 0));
      vt.push_back(v(0, 0, 40'h0,  0, 40'h0,  1,  0, 0, 1, 1, 40'hAA, 0));
      vt.push_back(v(0, 0, 40'h0,  0, 40'h0,  0,  0, 0, 0, 0, 40'h0,  0));
      vt.push_back(v(0, 1, 40'h33, 0, 40'h0,  0,  1, 0, 0, 0, 40'h0,  0));
      for (int i = 0; i < 5; i++)
         vt.push_back(v(0, 0, 40'h0, 1, 40'hBB, 0,  0, 0, 1, 1, 40'h33, 0));
      vt.push_back(v(0, 0, 40'h0,  1, 40'hBB, 1,  0, 1, 1, 1, 40'h33, 0));
      vt.push_back(v(0, 0, 40'h0,  0, 40'h0,  0,  0, 0, 1, 1, 40'hBB, 1));
      vt.push_back(v(0, 1, 40'h44, 0, 40'h0,  1,  1, 0, 1, 1, 40'hBB, 1));
      vt.push_back(v(0, 0, 40'h0,  0, 40'h0,  0,  0, 0, 1, 1, 40'h44, 0));

      foreach (vt[i]) begin
         drive(vt[i].mr, vt[i].sa, vt[i].pa, vt[i].sb, vt[i].pb, vt[i].ack);
         @(negedge CLK);
         chk($sformatf("vec%0d ack_a", i), 64'(bus.Ack_out_a), 64'(vt[i].ea));
         chk($sformatf("vec%0d ack_b", i), 64'(bus.Ack_out_b), 64'(vt[i].eb));
         chk($sformatf("vec%0d send_out", i), 64'(bus.Send_out), 64'(vt[i].eso));
         if (vt[i].epc) begin
            chk($sformatf("vec%0d packet", i), 64'(bus.PACKET_OUT), 64'(vt[i].ep));
            chk($sformatf("vec%0d sel", i), 64'(bus.SEL), 64'(vt[i].es));
         end
         next_cycle();
      end

      // ---------------- starvation bound: a,a,a,b repeating ----------------
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      next_cycle();
      drive(1'b0, 1'b1, 40'h100, 1'b1, 40'h200, 1'b1);
      prev_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         chk($sformatf("starve%0d ack_a", i), 64'(bus.Ack_out_a), 64'((i % 4) != 3));
         chk($sformatf("starve%0d ack_b", i), 64'(bus.Ack_out_b), 64'((i % 4) == 3));
         if (i > 0) chk($sformatf("starve%0d sel", i), 64'(bus.SEL), 64'(prev_b));
         prev_b = ((i % 4) == 3);
         next_cycle();
         if (prev_b) bus.PACKET_IN_EXTERNAL = bus.PACKET_IN_EXTERNAL + 1;
         else        bus.PACKET_IN_INTERNAL = bus.PACKET_IN_INTERNAL + 1;
      end

      // ---------------- streaming 1..8 ----------------
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 1'b1, WIDTH'(i), 1'b0, '0, 1'b1);
         @(negedge CLK);
         chk($sformatf("stream%0d ack_a", i), 64'(bus.Ack_out_a), 64'(1));
         chk($sformatf("stream%0d send_out", i), 64'(bus.Send_out), 64'(1));
         if (i > 1) chk($sformatf("stream%0d packet", i), 64'(bus.PACKET_OUT), 64'(i - 1));
         next_cycle();
      end
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      @(negedge CLK);
      chk("stream_last packet", 64'(bus.PACKET_OUT), 64'(8));
      chk("stream_last send_out", 64'(bus.Send_out), 64'(1));
      next_cycle();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge CLK);
      chk("stream_drain send_out", 64'(bus.Send_out), 64'(0));
      next_cycle();

      // ---------------- mid-operation reset ----------------
      drive(1'b0, 1'b1, 40'h55, 1'b0, '0, 1'b0);
      @(negedge CLK);
      chk("mr_load ack_a", 64'(bus.Ack_out_a), 64'(1));
      next_cycle();
      drive(1'b0, 1'b0, '0, 1'b1, 40'h66, 1'b0);
      @(negedge CLK);
      chk("mr_held packet", 64'(bus.PACKET_OUT), 64'(40'h55));
      chk("mr_held ack_b", 64'(bus.Ack_out_b), 64'(0));
      next_cycle();
      drive(1'b1, 1'b1, 40'h77, 1'b1, 40'h66, 1'b0);
      @(negedge CLK);
      chk("mr_during ack_a", 64'(bus.Ack_out_a), 64'(0));
      chk("mr_during ack_b", 64'(bus.Ack_out_b), 64'(0));
      next_cycle();
      drive(1'b0, 1'b0, '0, 1'b1, 40'h66, 1'b0);
      @(negedge CLK);
      chk("mr_after send_out", 64'(bus.Send_out), 64'(0));
      chk("mr_after packet", 64'(bus.PACKET_OUT), 64'(0));
      chk("mr_after ack_b", 64'(bus.Ack_out_b), 64'(1));
      next_cycle();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge CLK);
      chk("mr_reload packet", 64'(bus.PACKET_OUT), 64'(40'h66));
      chk("mr_reload sel", 64'(bus.SEL), 64'(1));
      next_cycle();

      // ---------------- randomized run vs. model ----------------
      got_a = 1'b0;
      got_b = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (!bus.Send_in_a || got_a) begin
            bus.Send_in_a          = ($urandom_range(0, 3) != 0);
            bus.PACKET_IN_INTERNAL = WIDTH'({$urandom, $urandom});
         end
         if (!bus.Send_in_b || got_b) begin
            bus.Send_in_b          = ($urandom_range(0, 3) != 0);
            bus.PACKET_IN_EXTERNAL = WIDTH'({$urandom, $urandom});
         end
         bus.Ack_in = ($urandom_range(0, 3) != 0);
         MR         = ($urandom_range(0, 49) == 0);
         @(negedge CLK);
         chk($sformatf("rnd%0d ack_a", c), 64'(bus.Ack_out_a), 64'(m_g == 1));
         chk($sformatf("rnd%0d ack_b", c), 64'(bus.Ack_out_b), 64'(m_g == 2));
         chk($sformatf("rnd%0d send_out", c), 64'(bus.Send_out), 64'(m_full));
         if (m_full) begin
            chk($sformatf("rnd%0d packet", c), 64'(bus.PACKET_OUT), 64'(m_pkt));
            chk($sformatf("rnd%0d sel", c), 64'(bus.SEL), 64'(m_sel));
         end
         got_a = bus.Ack_out_a;
         got_b = bus.Ack_out_b;
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
